user_clk_csr: RTL and testbench



---
 rtl/ccip_csr_pkg.sv | 80 ++++++++
 rtl/user_clk_csr_if.sv | 10 +
 rtl/user_clk_meas_fsm.sv | 109 ++++++++++
 rtl/user_clk_csr.sv | 143 ++++++++++++++
 tb/tb_user_clk_csr.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ccip_csr_pkg.sv
// Shared CCI-P MMIO types, CSR map and measurement FSM types for the user-clock-test AFU.
package ccip_csr_pkg;

    localparam int unsigned CCIP_MMIO_ADDR_W = 16;
    localparam int unsigned CCIP_MMIO_DATA_W = 64;
    localparam int unsigned CCIP_TID_W       = 9;
    localparam int unsigned CSR_QIDX_W       = CCIP_MMIO_ADDR_W - 1;

    // CSR byte offsets
    localparam logic [17:0] CSR_DFH        = 18'h00;
    localparam logic [17:0] CSR_AFU_ID_L   = 18'h08;
    localparam logic [17:0] CSR_AFU_ID_H   = 18'h10;
    localparam logic [17:0] CSR_RSVD0      = 18'h18;
    localparam logic [17:0] CSR_RSVD1      = 18'h20;
    localparam logic [17:0] CSR_SCRATCH    = 18'h28;
    localparam logic [17:0] CSR_CTRL       = 18'h30;
    localparam logic [17:0] CSR_STATUS     = 18'h38;
    localparam logic [17:0] CSR_PCLK_COUNT = 18'h40;
    localparam logic [17:0] CSR_USR_COUNT  = 18'h48;

    // MMIO request header as carried on c0 (address is a dword address)
    typedef struct packed {
        logic [CCIP_MMIO_ADDR_W-1:0] address;
        logic [1:0]                  length;
        logic                        rsvd;
        logic [CCIP_TID_W-1:0]       tid;
    } t_ccip_c0_ReqMmioHdr;

    // Rx c0 channel, MMIO-relevant subset
    typedef struct packed {
        t_ccip_c0_ReqMmioHdr         hdr;
        logic [CCIP_MMIO_DATA_W-1:0] data;
        logic                        rspValid;
        logic                        mmioRdValid;
        logic                        mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [CCIP_TID_W-1:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr         hdr;
        logic                        mmioRdValid;
        logic [CCIP_MMIO_DATA_W-1:0] data;
    } t_if_ccip_c2_Tx;

    typedef enum logic [1:0] {
        MEAS_IDLE   = 2'd0,
        MEAS_RUN    = 2'd1,
        MEAS_SETTLE = 2'd2,
        MEAS_DONE   = 2'd3
    } t_meas_state;

    // CTRL strobes: bit0 start, bit1 clear
    typedef struct packed {
        logic clear;
        logic start;
    } t_ctrl_reg;

    // Byte offset to qword index as seen on hdr.address[15:1]
    function automatic logic [CSR_QIDX_W-1:0] qword_idx(input logic [17:0] byte_off);
        return CSR_QIDX_W'(byte_off >> 3);
    endfunction

    // Device feature header: type[63:60], eol[40], next[39:16], feature id[11:0]
    function automatic logic [63:0] dfh_build(input logic [3:0]  ftype,
                                              input logic [23:0] next,
                                              input logic        eol,
                                              input logic [11:0] fid);
        return {ftype, 19'b0, eol, next, 4'b0, fid};
    endfunction

endpackage

// File: rtl/user_clk_csr_if.sv
// CCI-P MMIO path between the registered Rx port and the C2 response channel.
interface user_clk_csr_if;
    import ccip_csr_pkg::*;

    t_if_ccip_Rx    cp2af_sRxPort;
    t_if_ccip_c2_Tx af2cp_sTxC2;

    modport master (output cp2af_sRxPort, input  af2cp_sTxC2);
    modport slave  (input  cp2af_sRxPort, output af2cp_sTxC2);
endinterface

// File: rtl/user_clk_meas_fsm.sv
// Fixed-window measurement sequencer: gates the uClk counter and captures its result.
module user_clk_meas_fsm
    import ccip_csr_pkg::*;
#(
    parameter logic [63:0] WINDOW_CYCLES = 64'd400000,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  t_ctrl_reg   ctrl_c,
    input  logic [63:0] usr_count,
    output logic        meas_en,
    output logic        meas_clr,
    output logic        busy_c,
    output logic        done_c,
    output logic [63:0] pclk_count,
    output logic [63:0] usr_count_cap
);

    localparam int unsigned          SETTLE_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [63:0]          WINDOW_LAST = WINDOW_CYCLES - 64'd1;
    localparam logic [SETTLE_W-1:0]  SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    t_meas_state         state_q, state_d;
    logic                pend_q, pend_d;
    logic                meas_en_q, meas_en_d;
    logic                meas_clr_q, meas_clr_d;
    logic [63:0]         pclk_q, pclk_d;
    logic [63:0]         usrc_q, usrc_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= MEAS_IDLE;
            pend_q     <= 1'b0;
            meas_en_q  <= 1'b0;
            meas_clr_q <= 1'b0;
            pclk_q     <= '0;
            usrc_q     <= '0;
            settle_q   <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            meas_en_q  <= meas_en_d;
            meas_clr_q <= meas_clr_d;
            pclk_q     <= pclk_d;
            usrc_q     <= usrc_d;
            settle_q   <= settle_d;
        end
    end

    // Next state: a start spends one cycle clearing the uClk counter before RUN opens the window
    always_comb begin
        state_d    = state_q;
        pend_d     = 1'b0;
        meas_clr_d = 1'b0;
        pclk_d     = pclk_q;
        usrc_d     = usrc_q;
        settle_d   = settle_q;

        if (ctrl_c.clear) begin
            state_d    = MEAS_IDLE;
            meas_clr_d = 1'b1;
            pclk_d     = '0;
            usrc_d     = '0;
            settle_d   = '0;
        end else begin
            case (state_q)
                MEAS_IDLE, MEAS_DONE: begin
                    if (ctrl_c.start) begin
                        state_d    = MEAS_IDLE;
                        pend_d     = 1'b1;
                        meas_clr_d = 1'b1;
                        pclk_d     = '0;
                    end else if (pend_q) begin
                        state_d = MEAS_RUN;
                    end
                end
                MEAS_RUN: begin
                    pclk_d = pclk_q + 64'd1;
                    if (pclk_q == WINDOW_LAST) begin
                        state_d  = MEAS_SETTLE;
                        settle_d = '0;
                    end
                end
                MEAS_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        usrc_d  = usr_count;
                        state_d = MEAS_DONE;
                    end else begin
                        settle_d = settle_q + SETTLE_W'(1);
                    end
                end
                default: state_d = MEAS_IDLE;
            endcase
        end

        meas_en_d = (state_d == MEAS_RUN);
    end

    assign meas_en       = meas_en_q;
    assign meas_clr      = meas_clr_q;
    assign busy_c        = (state_q == MEAS_RUN) || (state_q == MEAS_SETTLE);
    assign done_c        = (state_q == MEAS_DONE);
    assign pclk_count    = pclk_q;
    assign usr_count_cap = usrc_q;

endmodule

// File: rtl/user_clk_csr.sv
// MMIO CSR block for the user-clock-test AFU: DFH/ID/scratch plus measurement control.
module user_clk_csr
    import ccip_csr_pkg::*;
#(
    parameter logic [63:0] AFU_ID_L      = 64'h0,
    parameter logic [63:0] AFU_ID_H      = 64'h0,
    parameter logic [63:0] WINDOW_CYCLES = 64'd400000,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic                 pClk,
    input  logic                 SoftReset,
    user_clk_csr_if.slave        mmio,
    output logic                 meas_en,
    output logic                 meas_clr,
    input  logic [63:0]          usr_count
);

    localparam logic [CSR_QIDX_W-1:0] Q_DFH        = qword_idx(CSR_DFH);
    localparam logic [CSR_QIDX_W-1:0] Q_AFU_ID_L   = qword_idx(CSR_AFU_ID_L);
    localparam logic [CSR_QIDX_W-1:0] Q_AFU_ID_H   = qword_idx(CSR_AFU_ID_H);
    localparam logic [CSR_QIDX_W-1:0] Q_RSVD0      = qword_idx(CSR_RSVD0);
    localparam logic [CSR_QIDX_W-1:0] Q_RSVD1      = qword_idx(CSR_RSVD1);
    localparam logic [CSR_QIDX_W-1:0] Q_SCRATCH    = qword_idx(CSR_SCRATCH);
    localparam logic [CSR_QIDX_W-1:0] Q_CTRL       = qword_idx(CSR_CTRL);
    localparam logic [CSR_QIDX_W-1:0] Q_STATUS     = qword_idx(CSR_STATUS);
    localparam logic [CSR_QIDX_W-1:0] Q_PCLK_COUNT = qword_idx(CSR_PCLK_COUNT);
    localparam logic [CSR_QIDX_W-1:0] Q_USR_COUNT  = qword_idx(CSR_USR_COUNT);
    localparam logic [63:0]           DFH_VALUE    = dfh_build(4'h1, 24'h0, 1'b1, 12'h0);

    t_if_ccip_Rx             rx_c;
    logic [CSR_QIDX_W-1:0]   qidx_c;
    logic                    unused_rx_c;

    logic [63:0]             scratch_q, scratch_d;
    t_ctrl_reg               ctrl_c;
    logic [63:0]             rd_data_c;

    logic                    rd_vld_q, rd_vld_d;
    logic [CCIP_TID_W-1:0]   rd_tid_q, rd_tid_d;
    logic [63:0]             rd_data_q, rd_data_d;
    t_if_ccip_c2_Tx          c2_q, c2_d;

    logic                    busy_c;
    logic                    done_c;
    logic [63:0]             pclk_count;
    logic [63:0]             usr_count_cap;

    assign rx_c        = mmio.cp2af_sRxPort;
    assign qidx_c      = rx_c.c0.hdr.address[15:1];
    assign unused_rx_c = ^{rx_c.c0TxAlmFull, rx_c.c1TxAlmFull, rx_c.c0.rspValid, rx_c.c0.hdr.rsvd};

    // Write decode: scratch update and CTRL strobes
    always_comb begin
        scratch_d = scratch_q;
        ctrl_c    = '0;
        if (rx_c.c0.mmioWrValid) begin
            if (qidx_c == Q_SCRATCH) begin
                if (rx_c.c0.hdr.length == 2'b01) begin
                    scratch_d = rx_c.c0.data;
                end else if (rx_c.c0.hdr.length == 2'b00) begin
                    if (rx_c.c0.hdr.address[0]) begin
                        scratch_d[63:32] = rx_c.c0.data[31:0];
                    end else begin
                        scratch_d[31:0]  = rx_c.c0.data[31:0];
                    end
                end
            end else if (qidx_c == Q_CTRL) begin
                if ((rx_c.c0.hdr.length == 2'b01) ||
                    ((rx_c.c0.hdr.length == 2'b00) && !rx_c.c0.hdr.address[0])) begin
                    ctrl_c = t_ctrl_reg'(rx_c.c0.data[1:0]);
                end
            end
        end
    end

    // Read mux: whole qword regardless of access length
    always_comb begin
        rd_data_c = '0;
        case (qidx_c)
            Q_DFH:        rd_data_c = DFH_VALUE;
            Q_AFU_ID_L:   rd_data_c = AFU_ID_L;
            Q_AFU_ID_H:   rd_data_c = AFU_ID_H;
            Q_RSVD0:      rd_data_c = '0;
            Q_RSVD1:      rd_data_c = '0;
            Q_SCRATCH:    rd_data_c = scratch_q;
            Q_CTRL:       rd_data_c = '0;
            Q_STATUS:     rd_data_c = {62'b0, done_c, busy_c};
            Q_PCLK_COUNT: rd_data_c = pclk_count;
            Q_USR_COUNT:  rd_data_c = usr_count_cap;
            default:      rd_data_c = '0;
        endcase
    end

    // Two-stage read response pipeline
    always_comb begin
        rd_vld_d  = rx_c.c0.mmioRdValid;
        rd_tid_d  = rx_c.c0.hdr.tid;
        rd_data_d = rd_data_c;

        c2_d             = '0;
        c2_d.mmioRdValid = rd_vld_q;
        if (rd_vld_q) begin
            c2_d.hdr.tid = rd_tid_q;
            c2_d.data    = rd_data_q;
        end
    end

    // CSR and response registers
    always_ff @(posedge pClk or posedge SoftReset) begin
        if (SoftReset) begin
            scratch_q <= '0;
            rd_vld_q  <= 1'b0;
            rd_tid_q  <= '0;
            rd_data_q <= '0;
            c2_q      <= '0;
        end else begin
            scratch_q <= scratch_d;
            rd_vld_q  <= rd_vld_d;
            rd_tid_q  <= rd_tid_d;
            rd_data_q <= rd_data_d;
            c2_q      <= c2_d;
        end
    end

    assign mmio.af2cp_sTxC2 = c2_q;

    user_clk_meas_fsm #(
        .WINDOW_CYCLES (WINDOW_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_meas_fsm (
        .clk           (pClk),
        .rst           (SoftReset),
        .ctrl_c        (ctrl_c),
        .usr_count     (usr_count),
        .meas_en       (meas_en),
        .meas_clr      (meas_clr),
        .busy_c        (busy_c),
        .done_c        (done_c),
        .pclk_count    (pclk_count),
        .usr_count_cap (usr_count_cap)
    );

endmodule

// File: tb/tb_user_clk_csr.sv
// Directed bench for user_clk_csr with a short measurement window.
module tb_user_clk_csr;
    import ccip_csr_pkg::*;

    localparam logic [63:0] ID_L = 64'h1122_3344_5566_7788;
    localparam logic [63:0] ID_H = 64'h99AA_BBCC_DDEE_FF00;
    localparam logic [63:0] DFH  = 64'h1000_0100_0000_0000;

    // dword addresses of the CSRs
    localparam logic [15:0] DW_DFH     = 16'h00;
    localparam logic [15:0] DW_ID_L    = 16'h02;
    localparam logic [15:0] DW_ID_H    = 16'h04;
    localparam logic [15:0] DW_RSVD0   = 16'h06;
    localparam logic [15:0] DW_SCRATCH = 16'h0A;
    localparam logic [15:0] DW_CTRL    = 16'h0C;
    localparam logic [15:0] DW_STATUS  = 16'h0E;
    localparam logic [15:0] DW_PCLK    = 16'h10;
    localparam logic [15:0] DW_USR     = 16'h12;
    localparam logic [15:0] DW_UNMAP   = 16'h40;

    logic        pClk = 1'b0;
    logic        SoftReset;
    logic        meas_en;
    logic        meas_clr;
    logic [63:0] usr_count;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    user_clk_csr_if mmio_if ();

    user_clk_csr #(
        .AFU_ID_L      (ID_L),
        .AFU_ID_H      (ID_H),
        .WINDOW_CYCLES (64'd100),
        .SETTLE_CYCLES (4)
    ) dut (
        .pClk      (pClk),
        .SoftReset (SoftReset),
        .mmio      (mmio_if.slave),
        .meas_en   (meas_en),
        .meas_clr  (meas_clr),
        .usr_count (usr_count)
    );

    always #5 pClk = ~pClk;

    always @(posedge pClk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic rx_idle();
        mmio_if.cp2af_sRxPort = '0;
    endtask

    task automatic drive_rd(input logic [15:0] dw, input logic [8:0] tid);
        mmio_if.cp2af_sRxPort                   = '0;
        mmio_if.cp2af_sRxPort.c0.hdr.address    = dw;
        mmio_if.cp2af_sRxPort.c0.hdr.tid        = tid;
        mmio_if.cp2af_sRxPort.c0.mmioRdValid    = 1'b1;
    endtask

    task automatic drive_wr(input logic [15:0] dw, input logic [1:0] len, input logic [63:0] data);
        mmio_if.cp2af_sRxPort                   = '0;
        mmio_if.cp2af_sRxPort.c0.hdr.address    = dw;
        mmio_if.cp2af_sRxPort.c0.hdr.length     = len;
        mmio_if.cp2af_sRxPort.c0.data           = data;
        mmio_if.cp2af_sRxPort.c0.mmioWrValid    = 1'b1;
    endtask

    // One-cycle write; returns at the following negedge with the bus idle
    task automatic wr(input logic [15:0] dw, input logic [1:0] len, input logic [63:0] data);
        drive_wr(dw, len, data);
        @(negedge pClk);
        rx_idle();
    endtask

    // Single read: checks no early response, the N+2 response and a one-cycle pulse
    task automatic rd_chk(input string tag, input logic [15:0] dw, input logic [8:0] tid,
                          input logic [63:0] exp_v);
        drive_rd(dw, tid);
        @(negedge pClk);
        rx_idle();
        chk({tag, "_early"}, 64'(mmio_if.af2cp_sTxC2.mmioRdValid), 64'd0);
        @(negedge pClk);
        chk({tag, "_vld"}, 64'(mmio_if.af2cp_sTxC2.mmioRdValid), 64'd1);
        chk({tag, "_tid"}, 64'(mmio_if.af2cp_sTxC2.hdr.tid), 64'(tid));
        chk({tag, "_data"}, mmio_if.af2cp_sTxC2.data, exp_v);
        @(negedge pClk);
        chk({tag, "_pulse"}, 64'(mmio_if.af2cp_sTxC2.mmioRdValid), 64'd0);
    endtask

    initial begin
        int unsigned k;
        int unsigned cnt;

        SoftReset = 1'b1;
        usr_count = 64'd75;
        rx_idle();
        repeat (2) @(negedge pClk);
        chk("rst_c2_vld", 64'(mmio_if.af2cp_sTxC2.mmioRdValid), 64'd0);
        chk("rst_c2_data", mmio_if.af2cp_sTxC2.data, 64'd0);
        chk("rst_c2_tid", 64'(mmio_if.af2cp_sTxC2.hdr.tid), 64'd0);
        chk("rst_meas_en", 64'(meas_en), 64'd0);
        chk("rst_meas_clr", 64'(meas_clr), 64'd0);
        SoftReset = 1'b0;
        @(negedge pClk);

        // DFH / ID reads back-to-back
        drive_rd(DW_DFH, 9'h011);
        @(negedge pClk);
        chk("b2b_early", 64'(mmio_if.af2cp_sTxC2.mmioRdValid), 64'd0);
        drive_rd(DW_ID_L, 9'h012);
        @(negedge pClk);
        chk("dfh_vld", 64'(mmio_if.af2cp_sTxC2.mmioRdValid), 64'd1);
        chk("dfh_tid", 64'(mmio_if.af2cp_sTxC2.hdr.tid), 64'h11);
        chk("dfh_data", mmio_if.af2cp_sTxC2.data, DFH);
        drive_rd(DW_ID_H, 9'h013);
        @(negedge pClk);
        chk("idl_vld", 64'(mmio_if.af2cp_sTxC2.mmioRdValid), 64'd1);
        chk("idl_tid", 64'(mmio_if.af2cp_sTxC2.hdr.tid), 64'h12);
        chk("idl_data", mmio_if.af2cp_sTxC2.data, ID_L);
        rx_idle();
        @(negedge pClk);
        chk("idh_vld", 64'(mmio_if.af2cp_sTxC2.mmioRdValid), 64'd1);
        chk("idh_tid", 64'(mmio_if.af2cp_sTxC2.hdr.tid), 64'h13);
        chk("idh_data", mmio_if.af2cp_sTxC2.data, ID_H);
        @(negedge pClk);
        chk("b2b_end", 64'(mmio_if.af2cp_sTxC2.mmioRdValid), 64'd0);

        // Reset values of the remaining registers
        rd_chk("rsvd0", DW_RSVD0, 9'h020, 64'd0);
        rd_chk("ctrl_rd", DW_CTRL, 9'h021, 64'd0);
        rd_chk("status_rst", DW_STATUS, 9'h022, 64'd0);
        rd_chk("pclk_rst", DW_PCLK, 9'h023, 64'd0);
        rd_chk("usr_rst", DW_USR, 9'h024, 64'd0);
        rd_chk("scratch_rst", DW_SCRATCH, 9'h025, 64'd0);

        // Scratch: 64-bit write then 32-bit half writes
        wr(DW_SCRATCH, 2'b01, 64'h0123_4567_89AB_CDEF);
        wr(DW_SCRATCH + 16'd1, 2'b00, 64'hFFFF_FFFF_DEAD_BEEF);
        rd_chk("scratch_hi", DW_SCRATCH, 9'h030, 64'hDEAD_BEEF_89AB_CDEF);
        wr(DW_SCRATCH, 2'b00, 64'hAAAA_AAAA_1234_5678);
        rd_chk("scratch_lo", DW_SCRATCH, 9'h031, 64'hDEAD_BEEF_1234_5678);

        // Unmapped address: zero data, write ignored
        rd_chk("unmap", DW_UNMAP, 9'h1FF, 64'd0);
        wr(DW_UNMAP, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
        rd_chk("unmap_wr", DW_SCRATCH, 9'h032, 64'hDEAD_BEEF_1234_5678);

        // 32-bit write to the upper CTRL dword has no effect
        wr(DW_CTRL + 16'd1, 2'b00, 64'h0000_0000_0000_0001);
        chk("ctrl_hi_clr", 64'(meas_clr), 64'd0);
        @(negedge pClk);
        chk("ctrl_hi_en", 64'(meas_en), 64'd0);
        rd_chk("ctrl_hi_status", DW_STATUS, 9'h033, 64'd0);

        // Measurement window
        k = cyc;
        wr(DW_CTRL, 2'b01, 64'd1);
        chk("run_clr_pulse", 64'(meas_clr), 64'd1);
        chk("run_en_pre", 64'(meas_en), 64'd0);
        @(negedge pClk);
        chk("run_clr_end", 64'(meas_clr), 64'd0);
        cnt = 0;
        while (meas_en && (cnt < 1000)) begin
            cnt++;
            @(negedge pClk);
        end
        chk("run_en_cycles", 64'(cnt), 64'd100);
        while (cyc < k + 110) @(negedge pClk);
        rd_chk("status_done", DW_STATUS, 9'h040, 64'd2);
        rd_chk("pclk_count", DW_PCLK, 9'h041, 64'd100);
        rd_chk("usr_count", DW_USR, 9'h042, 64'd75);

        // Start while busy is ignored, then start+clear together
        k = cyc;
        wr(DW_CTRL, 2'b01, 64'd1);
        @(negedge pClk);
        rd_chk("status_run", DW_STATUS, 9'h050, 64'd1);
        wr(DW_CTRL, 2'b01, 64'd1);
        chk("busy_start_clr", 64'(meas_clr), 64'd0);
        while (cyc < k + 101) @(negedge pClk);
        chk("busy_en_last", 64'(meas_en), 64'd1);
        @(negedge pClk);
        chk("busy_en_drop", 64'(meas_en), 64'd0);
        wr(DW_CTRL, 2'b01, 64'd3);
        chk("clr_pulse", 64'(meas_clr), 64'd1);
        chk("clr_en", 64'(meas_en), 64'd0);
        @(negedge pClk);
        chk("clr_pulse_end", 64'(meas_clr), 64'd0);
        repeat (3) @(negedge pClk);
        chk("clr_no_run", 64'(meas_en), 64'd0);
        rd_chk("clr_status", DW_STATUS, 9'h051, 64'd0);
        rd_chk("clr_pclk", DW_PCLK, 9'h052, 64'd0);
        rd_chk("clr_usr", DW_USR, 9'h053, 64'd0);

        // Reset during RUN, one cycle after a read request
        wr(DW_CTRL, 2'b01, 64'd1);
        @(negedge pClk);
        repeat (5) @(negedge pClk);
        chk("mid_en_pre", 64'(meas_en), 64'd1);
        drive_rd(DW_SCRATCH, 9'h055);
        @(negedge pClk);
        rx_idle();
        SoftReset = 1'b1;
        #1;
        chk("mid_en_async", 64'(meas_en), 64'd0);
        chk("mid_clr_async", 64'(meas_clr), 64'd0);
        chk("mid_c2_async", 64'(mmio_if.af2cp_sTxC2.mmioRdValid), 64'd0);
        @(negedge pClk);
        chk("mid_c2_rst", 64'(mmio_if.af2cp_sTxC2.mmioRdValid), 64'd0);
        SoftReset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pClk);
            chk("mid_no_late", 64'(mmio_if.af2cp_sTxC2.mmioRdValid), 64'd0);
        end
        chk("mid_en_post", 64'(meas_en), 64'd0);
        rd_chk("mid_status", DW_STATUS, 9'h060, 64'd0);
        rd_chk("mid_pclk", DW_PCLK, 9'h061, 64'd0);
        rd_chk("mid_usr", DW_USR, 9'h062, 64'd0);
        rd_chk("mid_scratch", DW_SCRATCH, 9'h063, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
